// File: rtl/serial_word_adder.sv
// Bit-serial unsigned adder: accepts one (a, b, cin) request, adds it LSB first over WIDTH
// cycles, then presents the registered sum and carry-out until the consumer takes them.
module serial_word_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // One full-adder slice operating on the current LSBs.
  logic s_bit;
  logic c_bit;

  always_comb begin
    s_bit = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    c_bit = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        s_sr_d  = {s_bit, s_sr_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = c_bit;
        if (cnt_q == LastBit) begin
          // Final bit: publish the completed word; counter stays at its maximum.
          sum_d   = {s_bit, s_sr_q[WIDTH-1:1]};
          cout_d  = c_bit;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StShift);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: doc/serial_word_adder.md
SERIAL_WORD_ADDER -- requirements
Module: serial_word_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits; legal values are WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, width 1: a, b and cin hold a request.
REQ-005 The block SHALL have port in_ready, output, width 1: the block accepts a request this cycle.
REQ-006 The block SHALL have port a, input, width WIDTH: operand A, unsigned.
REQ-007 The block SHALL have port b, input, width WIDTH: operand B, unsigned.
REQ-008 The block SHALL have port cin, input, width 1: carry-in for bit 0.
REQ-009 The block SHALL have port out_valid, output, width 1: sum and cout hold a result.
REQ-010 The block SHALL have port out_ready, input, width 1: the consumer takes the result this cycle.
REQ-011 The block SHALL have port sum, output, width WIDTH: registered result, (a+b+cin) mod 2^WIDTH.
REQ-012 The block SHALL have port cout, output, width 1: registered carry-out of bit WIDTH-1.
REQ-013 The block SHALL have port busy, output, width 1: high while in SHIFT.

Function
REQ-014 The block SHALL use three states, IDLE, SHIFT and DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE, and busy=1 only in SHIFT.
REQ-015 In IDLE, when in_valid=1 at a rising edge, the block SHALL load a and b into right-shift registers, load cin into the carry register, clear the bit counter, and enter SHIFT.
REQ-016 In IDLE with in_valid=0, the block SHALL hold all state, and sum and cout SHALL keep their last values.
REQ-017 Each SHIFT edge SHALL form s = a_sr[0]^b_sr[0]^carry and carry' = majority(a_sr[0], b_sr[0], carry), processing bits LSB first.
REQ-018 On the same SHIFT edge, the block SHALL shift s into the MSB of the sum shift register, shift a_sr and b_sr right by 1, and increment the counter.
REQ-019 When the counter equals WIDTH-1 at a SHIFT edge, the block SHALL process that final bit, copy the completed sum register to sum and the final carry' to cout, and enter DONE.
REQ-020 If the request is accepted at edge T, out_valid SHALL be 1 after edge T+WIDTH (latency WIDTH cycles).
REQ-021 In DONE, sum and cout SHALL remain stable while out_ready=0, for any number of cycles.
REQ-022 In DONE with out_ready=1 at an edge, the block SHALL return to IDLE.
REQ-023 After a DONE-to-IDLE transition, sum and cout SHALL retain their values.
REQ-024 in_valid, a, b and cin SHALL be ignored outside IDLE; operands SHALL be sampled only at the accepting edge, so later input changes do not affect the result.
REQ-025 The minimum initiation interval SHALL be WIDTH+2 cycles: accept, WIDTH shift edges, one DONE handshake edge, then IDLE.
REQ-026 The bit counter SHALL be $clog2(WIDTH) bits wide.
REQ-027 The bit counter SHALL never exceed WIDTH-1.
REQ-028 The arithmetic SHALL be exact for all 2^(2*WIDTH+1) input combinations, with no overflow flag other than cout.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL force state to IDLE and clear all shift registers, carry and counter to 0.
REQ-030 While rst=1 at a rising edge, the block SHALL set sum=0, cout=0, out_valid=0, busy=0 and in_ready=1 on the following cycle.
REQ-031 rst SHALL take priority over every other input, including in_valid and out_ready asserted in the same cycle.
REQ-032 rst asserted in SHIFT or DONE SHALL abort the operation with no result presented.
REQ-033 After rst deasserts, the first request SHALL be acceptable on the first edge.

Verification
REQ-034 With WIDTH=8, a=0x5A, b=0x3C, cin=0 accepted at edge T, the bench SHALL check out_valid=1 after edge T+8 with sum=0x96, cout=0.
REQ-035 With a=0xFF, b=0x01, cin=0, the bench SHALL check sum=0x00, cout=1; with a=0xFF, b=0xFF, cin=1, it SHALL check sum=0xFF, cout=1.
REQ-036 The bench SHALL hold out_ready=0 for 5 cycles in DONE and check sum and cout are unchanged; it SHALL then assert out_ready=1 and check IDLE with in_ready=1 on the next cycle.
REQ-037 The bench SHALL pulse in_valid with a=0x11, b=0x22 during SHIFT and check it is ignored, with the in-flight result correct and no second result produced.
REQ-038 The bench SHALL assert rst at the 4th SHIFT edge and check sum=0, cout=0, out_valid=0 and in_ready=1 next cycle; a following 0x01+0x01 request SHALL give sum=0x02.
REQ-039 The bench SHALL drive back-to-back requests with out_ready tied to 1 and check an initiation interval of 10 cycles and correct results against a reference model across 1000 random operand sets.
